// File: rtl/aemb2_dmem_ctrl.sv
// Data-memory access stage: one DWB transaction per load/store, big-endian
// byte-lane steering, aligned zero-extended load return and an ack timeout.
module aemb2_dmem_ctrl #(
  parameter int AEMB_DWB = 32,
  parameter int AEMB_DTO = 16
) (
  input  logic                  gclk,
  input  logic                  grst,
  input  logic [31:2]           mem_ex,
  input  logic [1:0]            off_ex,
  input  logic [1:0]            siz_ex,
  input  logic                  ld_ex,
  input  logic                  st_ex,
  input  logic [31:0]           opd_ex,
  output logic                  dena,
  output logic [AEMB_DWB-1:2]   dwb_adr_o,
  output logic [31:0]           dwb_dat_o,
  output logic [3:0]            dwb_sel_o,
  output logic                  dwb_we_o,
  output logic                  dwb_stb_o,
  output logic                  dwb_cyc_o,
  input  logic [31:0]           dwb_dat_i,
  input  logic                  dwb_ack_i,
  output logic [31:0]           ld_mx,
  output logic                  err_mx
);

  localparam int CW = $clog2(AEMB_DTO);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [1:0]      siz_q;
  logic [1:0]      off_q;
  logic            req;
  logic            timeout;
  logic [3:0]      sel_nxt;
  logic [31:0]     dat_nxt;
  logic [31:0]     ld_align;

  assign req       = ld_ex | st_ex;
  assign timeout   = (cnt == CW'(AEMB_DTO - 1));
  assign dwb_cyc_o = dwb_stb_o;

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_nxt = 4'b1111;
    dat_nxt = opd_ex;
    unique case (siz_ex)
      2'b00: begin
        sel_nxt = 4'b1000 >> off_ex;
        dat_nxt = {4{opd_ex[7:0]}};
      end
      2'b01: begin
        sel_nxt = off_ex[1] ? 4'b0011 : 4'b1100;
        dat_nxt = {2{opd_ex[15:0]}};
      end
      default: ;
    endcase
  end

  // Big-endian: offset 0 is the most significant lane.
  always_comb begin
    ld_align = dwb_dat_i;
    unique case (siz_q)
      2'b00: begin
        unique case (off_q)
          2'b00:   ld_align = {24'h0, dwb_dat_i[31:24]};
          2'b01:   ld_align = {24'h0, dwb_dat_i[23:16]};
          2'b10:   ld_align = {24'h0, dwb_dat_i[15:8]};
          default: ld_align = {24'h0, dwb_dat_i[7:0]};
        endcase
      end
      2'b01:   ld_align = off_q[1] ? {16'h0, dwb_dat_i[15:0]} : {16'h0, dwb_dat_i[31:16]};
      default: ;
    endcase
  end

  // The completing edge also advances EX, so the stall lifts in that same cycle.
  always_comb begin
    dena = 1'b0;
    if (state == IDLE) dena = ~req;
    else               dena = dwb_ack_i | timeout;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state     <= IDLE;
      cnt       <= '0;
      siz_q     <= 2'b00;
      off_q     <= 2'b00;
      dwb_adr_o <= '0;
      dwb_dat_o <= '0;
      dwb_sel_o <= '0;
      dwb_we_o  <= 1'b0;
      dwb_stb_o <= 1'b0;
      ld_mx     <= '0;
      err_mx    <= 1'b0;
    end else begin
      err_mx <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= BUSY;
            cnt       <= '0;
            siz_q     <= siz_ex;
            off_q     <= off_ex;
            dwb_adr_o <= mem_ex[AEMB_DWB-1:2];
            dwb_dat_o <= dat_nxt;
            dwb_sel_o <= sel_nxt;
            dwb_we_o  <= st_ex;
            dwb_stb_o <= 1'b1;
          end
        end
        BUSY: begin
          if (dwb_ack_i) begin
            state     <= IDLE;
            cnt       <= '0;
            dwb_we_o  <= 1'b0;
            dwb_stb_o <= 1'b0;
            if (!dwb_we_o) ld_mx <= ld_align;
          end else if (timeout) begin
            state     <= IDLE;
            cnt       <= '0;
            dwb_we_o  <= 1'b0;
            dwb_stb_o <= 1'b0;
            ld_mx     <= '0;
            err_mx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb2_dmem_ctrl.sv
// Directed bench for aemb2_dmem_ctrl: lane decode, store replication, load
// alignment, wait states, timeout, late ack, reset mid-transfer, back-to-back.
module tb_aemb2_dmem_ctrl;

  logic        gclk = 1'b0;
  logic        grst;
  logic [29:0] mem_ex;
  logic [1:0]  off_ex;
  logic [1:0]  siz_ex;
  logic        ld_ex;
  logic        st_ex;
  logic [31:0] opd_ex;
  logic        dena;
  logic [29:0] dwb_adr_o;
  logic [31:0] dwb_dat_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_we_o;
  logic        dwb_stb_o;
  logic        dwb_cyc_o;
  logic [31:0] dwb_dat_i;
  logic        dwb_ack_i;
  logic [31:0] ld_mx;
  logic        err_mx;

  int n_checks = 0;
  int n_errors = 0;

  aemb2_dmem_ctrl #(.AEMB_DWB(32), .AEMB_DTO(16)) dut (
    .gclk(gclk), .grst(grst),
    .mem_ex(mem_ex), .off_ex(off_ex), .siz_ex(siz_ex),
    .ld_ex(ld_ex), .st_ex(st_ex), .opd_ex(opd_ex),
    .dena(dena),
    .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_sel_o(dwb_sel_o),
    .dwb_we_o(dwb_we_o), .dwb_stb_o(dwb_stb_o), .dwb_cyc_o(dwb_cyc_o),
    .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
    .ld_mx(ld_mx), .err_mx(err_mx)
  );

  always #5 gclk = ~gclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  // One access against a slave that inserts `waits` wait states before ack.
  task automatic run_access(input string tag, input logic ld, input logic st,
                            input logic [1:0] siz, input logic [1:0] off,
                            input logic [29:0] adr, input logic [31:0] opd,
                            input logic [31:0] rdat, input int waits,
                            input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                            input logic [31:0] exp_ld);
    ld_ex = ld; st_ex = st; siz_ex = siz; off_ex = off; mem_ex = adr; opd_ex = opd;
    #1;
    check({tag, ".dena_req"}, dena, 0);
    tick();
    check({tag, ".adr"}, dwb_adr_o, adr);
    check({tag, ".sel"}, dwb_sel_o, exp_sel);
    check({tag, ".we"},  dwb_we_o, st);
    if (st) check({tag, ".dat_o"}, dwb_dat_o, exp_dat);
    for (int i = 0; i < waits; i++) begin
      check({tag, ".stb_wait"}, {dwb_cyc_o, dwb_stb_o}, 2'b11);
      check({tag, ".dena_wait"}, dena, 0);
      tick();
    end
    dwb_ack_i = 1'b1;
    dwb_dat_i = rdat;
    #1;
    check({tag, ".stb_ack"}, {dwb_cyc_o, dwb_stb_o}, 2'b11);
    check({tag, ".dena_ack"}, dena, 1);
    tick();
    ld_ex = 1'b0; st_ex = 1'b0; dwb_ack_i = 1'b0;
    #1;
    check({tag, ".stb_done"}, {dwb_cyc_o, dwb_stb_o, dwb_we_o}, 3'b000);
    check({tag, ".ld_mx"}, ld_mx, exp_ld);
    check({tag, ".err"}, err_mx, 0);
  endtask

  initial begin
    grst = 1'b1; mem_ex = '0; off_ex = '0; siz_ex = '0; ld_ex = 1'b0; st_ex = 1'b0;
    opd_ex = '0; dwb_dat_i = '0; dwb_ack_i = 1'b0;
    tick(); tick();
    grst = 1'b0;
    #1;
    check("rst.bus", {dwb_stb_o, dwb_cyc_o, dwb_we_o, dwb_sel_o}, 7'h00);
    check("rst.adr", dwb_adr_o, 0);
    check("rst.dat", dwb_dat_o, 0);
    check("rst.ld_mx", ld_mx, 0);
    check("rst.err", err_mx, 0);
    check("rst.dena", dena, 1);

    run_access("wld",   1, 0, 2'b10, 2'd0, 30'h40,  32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
    run_access("bst",   0, 1, 2'b00, 2'd1, 30'h41,  32'h000000A5, 32'h0,        2, 4'b0100, 32'hA5A5A5A5, 32'hDEADBEEF);
    run_access("hld2",  1, 0, 2'b01, 2'd2, 30'h42,  32'h0,        32'h1234ABCD, 1, 4'b0011, 32'h0,        32'h0000ABCD);
    run_access("hld0",  1, 0, 2'b01, 2'd0, 30'h42,  32'h0,        32'h1234ABCD, 0, 4'b1100, 32'h0,        32'h00001234);
    run_access("hld1",  1, 0, 2'b01, 2'd1, 30'h42,  32'h0,        32'h1234ABCD, 0, 4'b1100, 32'h0,        32'h00001234);
    run_access("bld3",  1, 0, 2'b00, 2'd3, 30'h43,  32'h0,        32'h1234ABCD, 0, 4'b0001, 32'h0,        32'h000000CD);
    run_access("bld0",  1, 0, 2'b00, 2'd0, 30'h43,  32'h0,        32'h1234ABCD, 1, 4'b1000, 32'h0,        32'h00000012);
    run_access("hst",   0, 1, 2'b01, 2'd3, 30'h44,  32'hFFFF1357, 32'h0,        0, 4'b0011, 32'h13571357, 32'h00000012);
    run_access("wst",   0, 1, 2'b11, 2'd2, 30'h45,  32'hCAFEF00D, 32'h0,        1, 4'b1111, 32'hCAFEF00D, 32'h00000012);
    run_access("ldst",  1, 1, 2'b10, 2'd0, 30'h46,  32'h0BADC0DE, 32'h55555555, 0, 4'b1111, 32'h0BADC0DE, 32'h00000012);

    // Timeout: 16 strobe cycles without ack, then error pulse and cleared ld_mx.
    ld_ex = 1'b1; siz_ex = 2'b10; off_ex = 2'd0; mem_ex = 30'h50;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("to.stb", dwb_stb_o, 1);
      check("to.dena", dena, (i == 15) ? 1 : 0);
      check("to.err_early", err_mx, 0);
      tick();
    end
    ld_ex = 1'b0;
    dwb_ack_i = 1'b1;
    dwb_dat_i = 32'hFFFFFFFF;
    #1;
    check("to.stb_end", {dwb_cyc_o, dwb_stb_o}, 2'b00);
    check("to.err", err_mx, 1);
    check("to.ld_mx", ld_mx, 0);
    check("to.dena_end", dena, 1);
    tick();
    dwb_ack_i = 1'b0;
    check("late.err", err_mx, 0);
    check("late.stb", dwb_stb_o, 0);
    check("late.ld_mx", ld_mx, 0);

    run_access("pre_rst", 1, 0, 2'b10, 2'd0, 30'h60, 32'h0, 32'h87654321, 0, 4'b1111, 32'h0, 32'h87654321);

    // Reset during the second wait cycle, with a concurrent ack that must not load.
    ld_ex = 1'b1; siz_ex = 2'b10; mem_ex = 30'h61;
    tick();
    tick();
    check("mid.stb_busy", dwb_stb_o, 1);
    grst = 1'b1; dwb_ack_i = 1'b1; dwb_dat_i = 32'hFFFFFFFF;
    tick();
    grst = 1'b0; dwb_ack_i = 1'b0; ld_ex = 1'b0;
    #1;
    check("mid.stb", {dwb_cyc_o, dwb_stb_o}, 2'b00);
    check("mid.ld_mx", ld_mx, 0);
    check("mid.err", err_mx, 0);
    check("mid.dena", dena, 1);

    // Back-to-back zero-wait load then store: dena 0,1,0,1.
    run_access("b2b_ld", 1, 0, 2'b10, 2'd0, 30'h70, 32'h0,        32'h0F0F0F0F, 0, 4'b1111, 32'h0,        32'h0F0F0F0F);
    run_access("b2b_st", 0, 1, 2'b00, 2'd2, 30'h71, 32'h0000003C, 32'h0,        0, 4'b0010, 32'h3C3C3C3C, 32'h0F0F0F0F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
